maq4_secuenciador: RTL and testbench

//   Controller for the 4-state (2-bit) stepping machine. Owns the 2-bit state register
//   and decides when it advances by one (mod 4), from either a debounced push-button
//   (manual mode) or a prescaled periodic tick (automatic mode).

---
 rtl/maq4_secuenciador.sv | 64 ++++++
 tb/tb_maq4_secuenciador.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/maq4_secuenciador.sv
// maq4_secuenciador: 2-bit mod-4 stepping controller driven by a debounced button or a prescaled auto tick
module maq4_secuenciador #(
  parameter int DEB_CYCLES = 1000,
  parameter int TICK_DIV   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       auto_en,
  input  logic       pause,
  input  logic       clr,
  output logic [1:0] Q,
  output logic       adv,
  output logic       wrap
);
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int PW = $clog2(TICK_DIV);
  logic          s1_q, s2_q, db_q, db_d, db_prev_q;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    q_q, q_d;
  logic          adv_q, adv_d, wrap_q, wrap_d;
  logic          run, tick, man_req, step, deb_done;
  always_comb begin
    run      = auto_en & ~pause;
    tick     = run & (pcnt_q == PW'(TICK_DIV - 1));
    man_req  = db_q & ~db_prev_q;
    step     = man_req | tick;
    deb_done = dcnt_q == DW'(DEB_CYCLES - 1);
    dcnt_d   = (s2_q == db_q || deb_done) ? '0 : dcnt_q + 1'b1;
    db_d     = (s2_q != db_q && deb_done) ? s2_q : db_q;
    // a paused or disabled prescaler restarts a full period on resume
    pcnt_d   = (clr | ~run | tick) ? '0 : pcnt_q + 1'b1;
    q_d      = clr ? 2'd0 : step ? q_q + 2'd1 : q_q;
    adv_d    = ~clr & step;
    wrap_d   = ~clr & step & (q_q == 2'd3);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      db_q      <= 1'b0;
      db_prev_q <= 1'b0;
      dcnt_q    <= '0;
      pcnt_q    <= '0;
      q_q       <= 2'd0;
      adv_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      s1_q      <= btn;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      dcnt_q    <= dcnt_d;
      pcnt_q    <= pcnt_d;
      q_q       <= q_d;
      adv_q     <= adv_d;
      wrap_q    <= wrap_d;
    end
  end
  assign Q    = q_q;
  assign adv  = adv_q;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_maq4_secuenciador.sv
// tb_maq4_secuenciador: cycle-by-cycle model comparison plus directed literal checkpoints
module tb_maq4_secuenciador;
  localparam int DEB = 4;
  localparam int DIV = 8;
  logic clk = 1'b0;
  logic rst, btn, auto_en, pause, clr;
  logic [1:0] Q;
  logic adv, wrap;
  int checks = 0;
  int errors = 0;

  maq4_secuenciador #(.DEB_CYCLES(DEB), .TICK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .btn(btn), .auto_en(auto_en), .pause(pause), .clr(clr),
    .Q(Q), .adv(adv), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Model: the debounced level flips once the button, seen two edges late,
  // has disagreed with it for DEB straight samples; auto steps land on every
  // DIV-th edge of an uninterrupted run.
  int m_q, m_adv, m_wrap, m_db, m_dbp, m_run;
  int bh [0:DEB+1];
  bit started = 0;

  always @(posedge clk) begin
    int flip, man, tk, runn;
    if (rst) begin
      m_q = 0; m_adv = 0; m_wrap = 0; m_db = 0; m_dbp = 0; m_run = 0;
      for (int k = 0; k <= DEB + 1; k++) bh[k] = 0;
    end else begin
      flip = 1;
      for (int k = 1; k <= DEB; k++) if (bh[k] == m_db) flip = 0;
      man  = (m_db == 1 && m_dbp == 0) ? 1 : 0;
      runn = (auto_en && !pause) ? 1 : 0;
      tk   = (runn == 1 && (m_run + 1) % DIV == 0) ? 1 : 0;
      if (clr) begin
        m_q = 0; m_adv = 0; m_wrap = 0;
      end else if (man == 1 || tk == 1) begin
        m_wrap = (m_q == 3) ? 1 : 0;
        m_q = (m_q + 1) % 4;
        m_adv = 1;
      end else begin
        m_adv = 0; m_wrap = 0;
      end
      m_run = (clr || runn == 0) ? 0 : m_run + 1;
      m_dbp = m_db;
      if (flip == 1) m_db = 1 - m_db;
      for (int k = DEB + 1; k >= 1; k--) bh[k] = bh[k-1];
      bh[0] = btn ? 1 : 0;
    end
    started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (int'(Q) != m_q || int'(adv) != m_adv || int'(wrap) != m_wrap) begin
        errors++;
        $display("FAIL model t=%0t: Q/adv/wrap got %0d/%0d/%0d expected %0d/%0d/%0d",
                 $time, Q, adv, wrap, m_q, m_adv, m_wrap);
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int exp_q [5] = '{1, 2, 3, 0, 1};
    int bounce [8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    rst = 1; btn = 1; auto_en = 1; pause = 0; clr = 0;
    // 1: reset with button and auto held, then release
    cyc(1);
    chk("rst_q_1", Q, 0); chk("rst_adv_1", adv, 0); chk("rst_wrap_1", wrap, 0);
    cyc(1);
    chk("rst_q_2", Q, 0); chk("rst_adv_2", adv, 0);
    rst = 0;
    cyc(6); chk("rst_rel_e6_q", Q, 0);
    cyc(1); chk("rst_rel_e7_q", Q, 1); chk("rst_rel_e7_adv", adv, 1);
    cyc(1); chk("rst_rel_e8_auto_q", Q, 2);
    auto_en = 0; btn = 0; clr = 1;
    cyc(1); clr = 0;
    chk("clr_q", Q, 0);
    cyc(10); chk("release_no_step", Q, 0);
    // 2: clean press
    btn = 1;
    cyc(6); chk("press_e6_q", Q, 0);
    cyc(1); chk("press_e7_q", Q, 1); chk("press_e7_adv", adv, 1);
    cyc(1); chk("press_e8_adv", adv, 0);
    cyc(12); btn = 0;
    cyc(10); chk("press_release_q", Q, 1);
    // 3: bounce then steady, then a short pulse
    for (int i = 0; i < 8; i++) begin btn = bounce[i][0]; cyc(1); end
    btn = 1;
    cyc(15); chk("bounce_single_step", Q, 2);
    btn = 0;
    cyc(10); chk("bounce_release", Q, 2);
    btn = 1; cyc(3); btn = 0;
    cyc(12); chk("short_pulse", Q, 2);
    // 4: automatic stepping and wrap
    clr = 1; cyc(1); clr = 0; auto_en = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(7); chk("auto_pre_q", Q, (i == 0) ? 0 : exp_q[i-1]);
      cyc(1); chk("auto_q", Q, exp_q[i]); chk("auto_wrap", wrap, (i == 3) ? 1 : 0);
    end
    clr = 1; cyc(1); clr = 0;
    cyc(20); chk("pause_pre_q", Q, 2);
    pause = 1; cyc(5); chk("paused_q", Q, 2);
    pause = 0;
    cyc(7); chk("resume_e7_q", Q, 2);
    cyc(1); chk("resume_e8_q", Q, 3); chk("resume_e8_adv", adv, 1);
    // 5: manual press and tick on the same edge with Q=2
    auto_en = 0; clr = 1; cyc(1); clr = 0; auto_en = 1;
    cyc(17); btn = 1;
    cyc(6); chk("coin_pre_q", Q, 2);
    cyc(1); chk("coin_q", Q, 3); chk("coin_adv", adv, 1);
    cyc(1); chk("coin_adv_drop", adv, 0); chk("coin_hold_q", Q, 3);
    // 6: clear beats a coincident tick, and restarts the prescaler
    cyc(6); clr = 1;
    cyc(1); clr = 0;
    chk("clr_step_q", Q, 0); chk("clr_step_adv", adv, 0); chk("clr_step_wrap", wrap, 0);
    cyc(3); clr = 1;
    cyc(1); clr = 0;
    cyc(7); chk("clr_pcnt_e7", Q, 0);
    cyc(1); chk("clr_pcnt_e8", Q, 1);
    auto_en = 0; btn = 0;
    cyc(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
